// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Optional word (RV64 *W) support in mdu_iter is enabled with MDU_WORD_OPS_EN.
package mdu_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHU  = 3'd2,
        OP_MULHSU = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    // rs1 is interpreted as two's complement
    function automatic logic is_signed_src1(input mdu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is interpreted as two's complement
    function automatic logic is_signed_src2(input mdu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_mul_op(input mdu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
    endfunction

    function automatic logic is_rem_op(input mdu_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module mdu_divstep #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dividend_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_c_o,
    output logic            qbit_c_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Partial remainder stays below the divisor, so the difference fits XLEN bits
    always_comb begin
        shifted  = {rem_i, dividend_bit_i};
        diff     = shifted - {1'b0, divisor_i};
        qbit_c_o = ~diff[XLEN];
        rem_c_o  = qbit_c_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide unit for the M extension.
// hi_q/lo_q form the shared datapath: {accumulator, multiplier} while
// multiplying, {partial remainder, dividend/quotient} while dividing.
// Define MDU_WORD_OPS_EN to add RV64 word-variant (32-bit, sign-extended) ops.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0]   MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [WORD_W-1:0] WORD_MIN  = {1'b1, {(WORD_W-1){1'b0}}};
    localparam logic [XLEN-1:0]   WORD_MASK = XLEN'({WORD_W{1'b1}});

    mdu_state_t      state_q, state_d;
    mdu_op_t         op_q, op_d;
    logic            neg_q, neg_d;
    logic            s1_q, s1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    mdu_op_t         op_in;
    logic            word_in;
    logic            sign1, sign2, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2, src1_fit;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_nx, mul_lo_nx, div_hi_nx, div_lo_nx, div_rem;
    logic              div_qbit;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   mul_res, div_res, quo_s, rem_s;

    assign op_in     = mdu_op_t'(op);
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

`ifdef MDU_WORD_OPS_EN
    logic              word_q, word_d;
    logic [WORD_W-1:0] word_prod;

    // Word mode only exists on RV64 and never for the high-half multiplies
    assign word_in = word && (XLEN == 64) && !(op_in inside {OP_MULH, OP_MULHU, OP_MULHSU});
`else
    logic unused_word;

    assign unused_word = word;
    assign word_in     = 1'b0;
`endif

    // Operand signs, magnitudes and divide special cases, evaluated in the accept cycle
    always_comb begin
        sign1    = is_signed_src1(op_in) & (word_in ? src1[WORD_W-1] : src1[XLEN-1]);
        sign2    = is_signed_src2(op_in) & (word_in ? src2[WORD_W-1] : src2[XLEN-1]);
        mag1     = sign1 ? -src1 : src1;
        mag2     = sign2 ? -src2 : src2;
        if (word_in) begin
            mag1 = mag1 & WORD_MASK;
            mag2 = mag2 & WORD_MASK;
        end
        src1_fit = word_in ? XLEN'($signed(src1[WORD_W-1:0])) : src1;
        div_zero = word_in ? (src2[WORD_W-1:0] == '0) : (src2 == '0);
        div_ovf  = is_signed_src2(op_in) && !is_mul_op(op_in) &&
                   (word_in ? (src1[WORD_W-1:0] == WORD_MIN && src2[WORD_W-1:0] == '1)
                            : (src1 == MIN_NEG && src2 == '1));
    end

    // Shift-add multiply step: conditionally add multiplicand, shift {hi,lo} right
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign mul_hi_nx = mul_sum[XLEN:1];
    assign mul_lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};

    mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_i          (hi_q),
        .dividend_bit_i (lo_q[XLEN-1]),
        .divisor_i      (b_q),
        .rem_c_o        (div_rem),
        .qbit_c_o       (div_qbit)
    );

    assign div_hi_nx = div_rem;
    assign div_lo_nx = {lo_q[XLEN-2:0], div_qbit};

    // Final signed results from the values produced by the last step
    always_comb begin
        prod    = {mul_hi_nx, mul_lo_nx};
        prod_s  = neg_q ? -prod : prod;
        mul_res = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        quo_s   = neg_q ? -div_lo_nx : div_lo_nx;
        rem_s   = s1_q ? -div_hi_nx : div_hi_nx;
        div_res = is_rem_op(op_q) ? rem_s : quo_s;
`ifdef MDU_WORD_OPS_EN
        // After 32 steps the low product word sits in the top half of lo
        word_prod = mul_lo_nx[XLEN-1 -: WORD_W];
        if (neg_q) begin
            word_prod = -word_prod;
        end
        if (word_q) begin
            mul_res = XLEN'($signed(word_prod));
            div_res = XLEN'($signed(div_res[WORD_W-1:0]));
        end
`endif
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        s1_d     = s1_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
`ifdef MDU_WORD_OPS_EN
        word_d   = word_q;
`endif

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d  = op_in;
                        neg_d = sign1 ^ sign2;
                        s1_d  = sign1;
                        b_d   = mag2;
                        hi_d  = '0;
`ifdef MDU_WORD_OPS_EN
                        word_d = word_in;
                        cnt_d  = word_in ? CNT_W'(WORD_W) : CNT_W'(XLEN);
`else
                        cnt_d  = CNT_W'(XLEN);
`endif
                        if (is_mul_op(op_in)) begin
                            lo_d    = mag1;
                            state_d = ST_MUL;
                        end else if (div_zero) begin
                            result_d = is_rem_op(op_in) ? src1_fit : '1;
                            state_d  = ST_DONE;
                        end else if (div_ovf) begin
                            result_d = is_rem_op(op_in) ? '0 : src1_fit;
                            state_d  = ST_DONE;
                        end else begin
                            // Word dividend is aligned to the top so 32 steps consume it
                            lo_d    = word_in ? (mag1 << (XLEN - WORD_W)) : mag1;
                            state_d = ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    hi_d  = mul_hi_nx;
                    lo_d  = mul_lo_nx;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) begin
                        result_d = mul_res;
                        state_d  = ST_DONE;
                    end
                end
                ST_DIV: begin
                    hi_d  = div_hi_nx;
                    lo_d  = div_lo_nx;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) begin
                        result_d = div_res;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            neg_q       <= 1'b0;
            s1_q        <= 1'b0;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            b_q         <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef MDU_WORD_OPS_EN
            word_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            s1_q        <= s1_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            b_q         <= b_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef MDU_WORD_OPS_EN
            word_q      <= word_d;
`endif
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=64): directed cases plus random ops
// checked against an arithmetic reference model.
module tb_mdu_iter;

    localparam logic [2:0] C_MUL = 3'd0, C_MULH = 3'd1, C_MULHU = 3'd2, C_MULHSU = 3'd3;
    localparam logic [2:0] C_DIV = 3'd4, C_DIVU = 3'd5, C_REM = 3'd6, C_REMU = 3'd7;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, word, out_valid, out_ready;
    logic [2:0]  op;
    logic [63:0] src1, src2, result;

    int n_checks = 0;
    int n_errors = 0;

    mdu_iter #(.XLEN(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .word      (word),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: result and cycles-to-out_valid derived from RISC-V M semantics
    task automatic ref_model(input logic [2:0] o, input logic w, input logic [63:0] a,
                             input logic [63:0] b, output logic [63:0] r, output int lat);
        logic        weff, sg, special;
        logic [63:0] aa, bb, minv, q, m;
        logic [127:0] p;
`ifdef MDU_WORD_OPS_EN
        weff = w && !(o inside {C_MULH, C_MULHU, C_MULHSU});
`else
        weff = 1'b0;
`endif
        special = 1'b0;
        r = '0;
        case (o)
            C_MUL:    begin p = {64'b0, a} * {64'b0, b};               r = p[63:0];   end
            C_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b};   r = p[127:64]; end
            C_MULHU:  begin p = {64'b0, a} * {64'b0, b};               r = p[127:64]; end
            C_MULHSU: begin p = {{64{a[63]}}, a} * {64'b0, b};         r = p[127:64]; end
            default: begin
                sg = (o == C_DIV) || (o == C_REM);
                if (weff) begin
                    aa   = sg ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
                    bb   = sg ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
                    minv = 64'hFFFF_FFFF_8000_0000;
                end else begin
                    aa   = a;
                    bb   = b;
                    minv = 64'h8000_0000_0000_0000;
                end
                if (bb == 64'd0) begin
                    q = ALL1; m = aa; special = 1'b1;
                end else if (sg && aa == minv && bb == ALL1) begin
                    q = aa; m = 64'd0; special = 1'b1;
                end else if (sg) begin
                    q = 64'($signed(aa) / $signed(bb));
                    m = 64'($signed(aa) % $signed(bb));
                end else begin
                    q = aa / bb;
                    m = aa % bb;
                end
                r = (o == C_REM || o == C_REMU) ? m : q;
            end
        endcase
        if (weff) r = {{32{r[31]}}, r[31:0]};
        lat = special ? 1 : (weff ? 33 : 65);
    endtask

    // Issue one op, wait for the result, hold it, then hand it off
    task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input int hold,
                          input bit use_exp, input logic [63:0] exp_r_in, input int exp_lat_in);
        logic [63:0] exp_r;
        int exp_lat, lat;
        if (use_exp) begin
            exp_r = exp_r_in; exp_lat = exp_lat_in;
        end else begin
            ref_model(o, w, a, b, exp_r, exp_lat);
        end
        @(negedge clock);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; word = w; src1 = a; src2 = b;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        op = 3'($urandom); word = 1'($urandom);
        src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".result"}, result, exp_r);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_result"}, result, exp_r);
        end
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, ".ready_back"}, 64'(in_ready), 64'd1);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 8))
            0:       return 64'd0;
            1:       return ALL1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 20));
            4:       return {32'h0, $urandom};
            5:       return {$urandom, 32'h8000_0000};
            6:       return {$urandom, 32'hFFFF_FFFF};
            7:       return {$urandom, 32'h0};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; word = 1'b0; src1 = '0; src2 = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.result", result, 64'd0);
        reset = 1'b0;

        run_op("mul_neg3x7", C_MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        run_op("mulhsu", C_MULHSU, 1'b0, ALL1, ALL1, 0, 1'b1, ALL1, 65);
        run_op("mulhu", C_MULHU, 1'b0, ALL1, ALL1, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("div_m7_2", C_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem_m7_2", C_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1'b1, ALL1, 65);
        run_op("divu_100_7", C_DIVU, 1'b0, 64'd100, 64'd7, 0, 1'b1, 64'd14, 65);
        run_op("remu_100_7", C_REMU, 1'b0, 64'd100, 64'd7, 0, 1'b1, 64'd2, 65);
        run_op("div_by0", C_DIV, 1'b0, 64'd5, 64'd0, 2, 1'b1, ALL1, 1);
        run_op("remu_by0", C_REMU, 1'b0, 64'd5, 64'd0, 0, 1'b1, 64'd5, 1);
        run_op("div_ovf", C_DIV, 1'b0, 64'h8000_0000_0000_0000, ALL1, 0, 1'b1, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf", C_REM, 1'b0, 64'h8000_0000_0000_0000, ALL1, 0, 1'b1, 64'd0, 1);
        run_op("div_6_m1", C_DIV, 1'b0, 64'd6, ALL1, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 65);

        // Flush coincident with a request: nothing is accepted
        @(negedge clock);
        in_valid = 1'b1; op = C_DIV; word = 1'b0; src1 = 64'd5; src2 = 64'd0; flush = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_req.in_ready", 64'(in_ready), 64'd1);
        check("flush_req.out_valid", 64'(out_valid), 64'd0);

        // Flush in the middle of a divide
        in_valid = 1'b1; op = C_DIV; src1 = 64'd1000; src2 = 64'd7;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (19) @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        @(negedge clock);
        flush = 1'b0;
        check("flush_div.in_ready", 64'(in_ready), 64'd1);
        check("flush_div.out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        check("flush_div.never_valid", 64'(seen), 64'd0);
        run_op("mul_3x4", C_MUL, 1'b0, 64'd3, 64'd4, 0, 1'b1, 64'd12, 65);

        // Reset in the middle of a multiply
        @(negedge clock);
        in_valid = 1'b1; op = C_MUL; src1 = 64'd5; src2 = 64'd5;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset_mid.in_ready", 64'(in_ready), 64'd1);
        check("reset_mid.out_valid", 64'(out_valid), 64'd0);
        check("reset_mid.result", result, 64'd0);

`ifdef MDU_WORD_OPS_EN
        run_op("divw_ovf", C_DIV, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 1'b1,
               64'hFFFF_FFFF_8000_0000, 1);
        run_op("mulw", C_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
`endif

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), 1'($urandom), rand_operand(), rand_operand(),
                   $urandom_range(0, 2), 1'b0, 64'd0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
